// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Write-side initiator for the instruction memory. Receives a program image as
// a byte stream over a valid/ready handshake, assembles little-endian 32-bit
// words and issues one-cycle write strobes on the memory write port. Holds the
// core off fetch (busy) until the whole image has been written.
//
// Image format (little-endian): 4-byte word count N, then N words of 4 bytes.
// With IMEM_LOADER_CKSUM_EN defined, a 4-byte checksum (sum of the N words,
// mod 2**32) follows the data and is compared before reporting done.
//
// Parameters:
//   ADDR_W     word-address width, memory depth is 2**ADDR_W words
//   BASE_ADDR  word index of the first instruction written
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   start         one-cycle pulse, begins a load from IDLE, DONE or ERR
//   in_data       image byte
//   in_valid      in_data valid
//   in_ready      loader accepts a byte this cycle
//   mem_waddr     word index to instruction memory, zero-extended
//   mem_wdata     assembled instruction word
//   mem_we        write strobe, one cycle per word
//   busy          load in progress
//   done          image loaded successfully (level, until next start)
//   error         load aborted (level, until next start)
//   words_loaded  words written in the current load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [31:0]       mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  // Largest word count that still fits between BASE_ADDR and the top of memory.
  localparam logic [32:0]       MAX_WORDS = 33'((64'd1 << ADDR_W) - 64'(BASE_ADDR));
  localparam logic [ADDR_W-1:0] BASE_W    = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
`ifdef IMEM_LOADER_CKSUM_EN
    S_CKSUM,
`endif
    S_DONE,
    S_ERR
  } state_e;

  state_e state_q, state_d;

  logic [1:0]      lane_q, lane_d;     // byte position within the current word
  logic [31:0]     shift_q, shift_d;   // word under assembly, bytes enter at the top
  logic [ADDR_W:0] count_q, count_d;   // header word count N (range-checked)
  logic [ADDR_W:0] words_q, words_d;
  logic [31:0]     waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [31:0]     sum_q, sum_d;
`endif

  logic        accept;
  logic        last_byte;
  logic        start_ok;
  logic [31:0] word_next;
  logic        last_word;

  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (lane_q == 2'd3);
  // Shifting right means the first byte received lands in bits 7:0 after four bytes.
  assign word_next = {in_data, shift_q[31:8]};
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign last_word = (words_q + 1'b1) == count_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_HDR;
      S_HDR: begin
        if (last_byte) begin
          if (word_next == 32'd0) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state_d = S_CKSUM;
`else
            state_d = S_DONE;
`endif
          end else if ({1'b0, word_next} > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_byte && last_word) begin
`ifdef IMEM_LOADER_CKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM: if (last_byte) state_d = (word_next == sum_q) ? S_DONE : S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode (depends on registered state only)
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      S_HDR, S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CKSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      S_DONE:  done  = 1'b1;
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    count_d = count_q;
    words_d = words_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;     // strobe lasts exactly one cycle
`ifdef IMEM_LOADER_CKSUM_EN
    sum_d   = sum_q;
`endif
    if (start_ok) begin
      lane_d  = 2'd0;
      words_d = '0;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_d   = 32'd0;
`endif
    end else if (accept) begin
      shift_d = word_next;
      lane_d  = lane_q + 2'd1;
      if (last_byte) begin
        if (state_q == S_HDR) begin
          // Only meaningful once the range check passes, where N fits ADDR_W+1 bits.
          count_d = word_next[ADDR_W:0];
        end else if (state_q == S_DATA) begin
          we_d    = 1'b1;
          wdata_d = word_next;
          waddr_d = 32'(BASE_W + words_q[ADDR_W-1:0]);
          words_d = words_q + 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
          sum_d   = sum_q + word_next;
`endif
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= 2'd0;
      shift_q <= 32'd0;
      count_q <= '0;
      words_q <= '0;
      waddr_q <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q   <= 32'd0;
`endif
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
      count_q <= count_d;
      words_q <= words_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign mem_waddr    = waddr_q;
  assign mem_wdata    = wdata_q;
  assign mem_we       = we_q;
  assign words_loaded = words_q;

endmodule
